// File: rtl/rv_pipe_pkg.sv
// Shared pipeline encodings: ALU operation codes, main-op classes and
// forwarding-source selects used by the ID/EX stage and its ALU control.
package rv_pipe_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b0111;

  localparam logic [1:0] MAIN_MEM   = 2'b00;
  localparam logic [1:0] MAIN_BR    = 2'b01;
  localparam logic [1:0] MAIN_ARITH = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_EXM = 2'b10;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALUOp decode from the main-op class and funct fields.
module alu_control
  import rv_pipe_pkg::*;
(
  input  logic [1:0] main_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       is_rtype_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (main_op_i)
      MAIN_MEM: alu_op_o = ALU_ADD;
      MAIN_BR:  alu_op_o = ALU_SUB;
      MAIN_ARITH: begin
        case (funct3_i)
          // addi shares funct3 000 with add/sub; only R-type honours bit 30
          3'b000:  alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op_o = ALU_AND;
          3'b110:  alu_op_o = ALU_OR;
          3'b001:  alu_op_o = ALU_SLL;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      default:  alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control, operand forwarding
// from EX/MEM and MEM/WB, and ALUOp generation for the downstream ALU.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_is_rtype,
  input  logic [1:0]      id_alu_op_main,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            is_rtype;
    logic [1:0]      alu_op_main;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
  } stage_t;

  stage_t stage_q, stage_d;

  // Flush beats stall: a bubble replaces even a held instruction.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid       = id_valid;
      stage_d.pc          = id_pc;
      stage_d.rs1_data    = id_rs1_data;
      stage_d.rs2_data    = id_rs2_data;
      stage_d.imm         = id_imm;
      stage_d.rs1         = id_rs1;
      stage_d.rs2         = id_rs2;
      stage_d.rd          = id_rd;
      stage_d.funct3      = id_funct3;
      stage_d.funct7_5    = id_funct7_5;
      stage_d.is_rtype    = id_is_rtype;
      stage_d.alu_op_main = id_alu_op_main;
      stage_d.alu_src     = id_alu_src;
      stage_d.reg_write   = id_reg_write;
      stage_d.mem_read    = id_mem_read;
      stage_d.mem_write   = id_mem_write;
      stage_d.mem_to_reg  = id_mem_to_reg;
      stage_d.branch      = id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  // x0 is never a forwarding source; EX/MEM is the younger result and wins.
  function automatic logic [1:0] fwd_sel(input logic            rw_exm,
                                         input logic [RA_W-1:0] rd_exm,
                                         input logic            rw_wb,
                                         input logic [RA_W-1:0] rd_wb,
                                         input logic [RA_W-1:0] rs);
    if (rw_exm && (rd_exm != '0) && (rd_exm == rs)) return FWD_EXM;
    if (rw_wb && (rd_wb != '0) && (rd_wb == rs))    return FWD_WB;
    return FWD_REG;
  endfunction

  logic [1:0]      sel_a, sel_b;
  logic [XLEN-1:0] fwd_a, fwd_b;

  assign sel_a = fwd_sel(exm_reg_write, exm_rd, wb_reg_write, wb_rd, stage_q.rs1);
  assign sel_b = fwd_sel(exm_reg_write, exm_rd, wb_reg_write, wb_rd, stage_q.rs2);

  always_comb begin
    fwd_a = stage_q.rs1_data;
    fwd_b = stage_q.rs2_data;
    case (sel_a)
      FWD_EXM: fwd_a = exm_result;
      FWD_WB:  fwd_a = wb_data;
      default: fwd_a = stage_q.rs1_data;
    endcase
    case (sel_b)
      FWD_EXM: fwd_b = exm_result;
      FWD_WB:  fwd_b = wb_data;
      default: fwd_b = stage_q.rs2_data;
    endcase
  end

  assign alu_a         = fwd_a;
  assign alu_b         = stage_q.alu_src ? stage_q.imm : fwd_b;
  assign ex_store_data = fwd_b;

  alu_control u_alu_control (
    .main_op_i  (stage_q.alu_op_main),
    .funct3_i   (stage_q.funct3),
    .funct7_5_i (stage_q.funct7_5),
    .is_rtype_i (stage_q.is_rtype),
    .alu_op_o   (alu_op)
  );

  assign ex_valid      = stage_q.valid;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_mem_to_reg = stage_q.mem_to_reg;
  assign ex_branch     = stage_q.branch;
  assign ex_rd         = stage_q.rd;
  assign ex_rs1        = stage_q.rs1;
  assign ex_rs2        = stage_q.rs2;
  assign ex_pc         = stage_q.pc;
  assign ex_imm        = stage_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps then random traffic against a
// behavioural model of the stage contents and forwarding rules.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_5, id_is_rtype;
  logic [1:0]  id_alu_op_main;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [63:0] exm_result, wb_data;
  logic [63:0] alu_a, alu_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .id_is_rtype(id_is_rtype),
    .id_alu_op_main(id_alu_op_main), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  // Model of the instruction currently held in EX.
  logic        m_valid, m_f75, m_rt, m_src, m_rw, m_mr, m_mw, m_m2r, m_br;
  logic [63:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_main;

  task automatic model_clear();
    {m_valid, m_f75, m_rt, m_src, m_rw, m_mr, m_mw, m_m2r, m_br} = '0;
    {m_pc, m_d1, m_d2, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_f3, m_main} = '0;
  endtask

  task automatic model_edge();
    if (!reset || flush) model_clear();
    else if (!stall) begin
      m_valid = id_valid; m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
      m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_f3 = id_funct3; m_f75 = id_funct7_5; m_rt = id_is_rtype; m_main = id_alu_op_main;
      m_src = id_alu_src; m_rw = id_reg_write; m_mr = id_mem_read;
      m_mw = id_mem_write; m_m2r = id_mem_to_reg; m_br = id_branch;
    end
  endtask

  function automatic logic [63:0] exp_fwd(input logic [4:0] rs, input logic [63:0] regval);
    if (exm_reg_write && exm_rd != 0 && exm_rd == rs) return exm_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_data;
    return regval;
  endfunction

  function automatic logic [3:0] exp_aluop();
    if (m_main == 2'd1) return 4'b0110;
    if (m_main != 2'd2) return 4'b0010;
    if (m_f3 == 3'd0) return (m_rt && m_f75) ? 4'b0110 : 4'b0010;
    if (m_f3 == 3'd7) return 4'b0000;
    if (m_f3 == 3'd6) return 4'b0001;
    if (m_f3 == 3'd1) return 4'b0111;
    return 4'b0010;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ex_valid"}, 64'(ex_valid), 64'(m_valid));
    chk({tag, " ex_reg_write"}, 64'(ex_reg_write), 64'(m_rw));
    chk({tag, " ex_mem_read"}, 64'(ex_mem_read), 64'(m_mr));
    chk({tag, " ex_mem_write"}, 64'(ex_mem_write), 64'(m_mw));
    chk({tag, " ex_mem_to_reg"}, 64'(ex_mem_to_reg), 64'(m_m2r));
    chk({tag, " ex_branch"}, 64'(ex_branch), 64'(m_br));
    chk({tag, " ex_rd"}, 64'(ex_rd), 64'(m_rd));
    chk({tag, " ex_rs1"}, 64'(ex_rs1), 64'(m_rs1));
    chk({tag, " ex_rs2"}, 64'(ex_rs2), 64'(m_rs2));
    chk({tag, " ex_pc"}, ex_pc, m_pc);
    chk({tag, " ex_imm"}, ex_imm, m_imm);
    chk({tag, " alu_a"}, alu_a, exp_fwd(m_rs1, m_d1));
    chk({tag, " alu_b"}, alu_b, m_src ? m_imm : exp_fwd(m_rs2, m_d2));
    chk({tag, " store_data"}, ex_store_data, exp_fwd(m_rs2, m_d2));
    chk({tag, " alu_op"}, 64'(alu_op), 64'(exp_aluop()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_id();
    id_valid = 1'($urandom); id_pc = r64(); id_rs1_data = r64(); id_rs2_data = r64();
    id_imm = r64(); id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom); id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
    id_is_rtype = 1'($urandom); id_alu_op_main = 2'($urandom); id_alu_src = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    id_mem_to_reg = 1'($urandom); id_branch = 1'($urandom);
  endtask

  task automatic rand_fwd();
    exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = r64();
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = r64();
  endtask

  task automatic set_id(input logic [1:0] main, input logic [2:0] f3, input logic f75,
                        input logic rt, input logic src);
    id_valid = 1; id_alu_op_main = main; id_funct3 = f3; id_funct7_5 = f75;
    id_is_rtype = rt; id_alu_src = src;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
  endtask

  logic [5:0] sweep [6];
  logic [1:0] sw_main;
  logic [2:0] sw_f3;
  logic       sw_f75;

  initial begin
    model_clear();
    reset = 0; stall = 0; flush = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    rand_id();

    // Reset with random ID inputs
    tick();
    check_all("reset");
    chk("reset alu_op literal", 64'(alu_op), 64'h2);
    chk("reset alu_a literal", alu_a, 64'h0);

    // add x3,x1,x2
    reset = 1;
    set_id(2'b10, 3'b000, 0, 1, 0);
    id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 5; id_rs2_data = 7;
    id_pc = 64'h100; id_imm = 0;
    tick();
    check_all("add");
    chk("add alu_a", alu_a, 64'd5);
    chk("add alu_b", alu_b, 64'd7);

    // sub with double forwarding match on rs1
    set_id(2'b10, 3'b000, 1, 1, 0);
    id_rs1 = 1; id_rs2 = 2;
    exm_reg_write = 1; exm_rd = 1; exm_result = 100;
    wb_reg_write = 1; wb_rd = 1; wb_data = 200;
    tick();
    check_all("sub fwd");
    chk("sub exm priority", alu_a, 64'd100);
    chk("sub alu_op", 64'(alu_op), 64'h6);
    exm_reg_write = 0; #1;
    check_all("sub wb");
    chk("sub wb value", alu_a, 64'd200);

    // x0 destination never forwards
    set_id(2'b10, 3'b000, 0, 1, 0);
    id_rs1 = 0; id_rs1_data = 0; wb_reg_write = 0;
    exm_reg_write = 1; exm_rd = 0; exm_result = 64'hDEAD;
    tick();
    check_all("x0");
    chk("x0 alu_a", alu_a, 64'd0);

    // sd with immediate and MEM/WB store-data forwarding
    set_id(2'b00, 3'b011, 0, 0, 1);
    id_reg_write = 0; id_mem_write = 1; id_imm = 16; id_rs1 = 2; id_rs2 = 5;
    exm_reg_write = 0; wb_reg_write = 1; wb_rd = 5; wb_data = 64'h55;
    tick();
    check_all("sd");
    chk("sd alu_b", alu_b, 64'd16);
    chk("sd store", ex_store_data, 64'h55);

    // Stall three cycles with changing ID inputs
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      check_all("stall");
      chk("stall hold imm", ex_imm, 64'd16);
    end
    flush = 1; rand_id();
    tick();
    check_all("stall+flush");
    chk("flush valid", 64'(ex_valid), 64'd0);
    chk("flush reg_write", 64'(ex_reg_write), 64'd0);
    stall = 0; flush = 0;

    // Decode sweep: {main, funct3, f7_5}, R-type cleared for addi
    sweep[0] = {2'b10, 3'b000, 1'b1};
    sweep[1] = {2'b10, 3'b111, 1'b0};
    sweep[2] = {2'b10, 3'b110, 1'b0};
    sweep[3] = {2'b10, 3'b001, 1'b0};
    sweep[4] = {2'b10, 3'b010, 1'b0};
    sweep[5] = {2'b01, 3'b000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      {sw_main, sw_f3, sw_f75} = sweep[i];
      rand_id();
      set_id(sw_main, sw_f3, sw_f75, (i == 0) ? 1'b0 : 1'b1, 0);
      tick();
      check_all("decode");
    end
    chk("beq alu_op", 64'(alu_op), 64'h6);

    // Random traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      rand_id(); rand_fwd();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 19) != 0);
      tick();
      check_all("random");
      rand_fwd(); #1;
      check_all("random fwd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
